// File: rtl/bit_slicer_stream.sv
// bit_slicer_stream: accepts one wide word per handshake and emits it
// as one top slice or as a serialised slice stream, with a selector field.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   in_valid_i/in_ready_o    input word handshake
//   data_i                   input word (DATA_W)
//   mode_i                   0 = top slice only, 1 = all slices
//   msb_first_i              1 = serialise from the top slice down
//   out_valid_o/out_ready_i  output slice handshake
//   data_o                   current slice (SLICE_W)
//   idx_o                    slice index within the word
//   last_o                   final slice of the word
//   field_o                  selector field, held for the whole word
module bit_slicer_stream #(
  parameter int DATA_W      = 32,
  parameter int SLICE_W     = 8,
  parameter int FIELD_W     = 4,
  parameter int CHK_W       = 5,
  parameter int FIELD_A_LSB = 1,
  parameter int FIELD_B_LSB = 9,
  localparam int NSLICE = DATA_W / SLICE_W,
  localparam int IDX_W  = $clog2(NSLICE)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               mode_i,
  input  logic               msb_first_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [SLICE_W-1:0] data_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               last_o,
  output logic [FIELD_W-1:0] field_o
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NSLICE - 1);
  localparam logic [IDX_W-1:0] ONE =
    IDX_W'(1);

  state_e state_q, state_d;

  logic [DATA_W-1:0]  word_q;
  logic               msb_q;
  logic [IDX_W-1:0]   idx_q;
  logic               last_q;
  logic [FIELD_W-1:0] field_q;

  logic               valid;
  logic               accept;
  logic               beat;
  logic               adv;
  logic [IDX_W-1:0]   idx_nx;
  logic               last_nx;
  logic [IDX_W-1:0]   ld_idx;
  logic [FIELD_W-1:0] field_nx;

  assign valid  = (state_q == EMIT);
  assign beat   = valid && out_ready_i;
  assign accept = in_valid_i && in_ready_o;
  // Mode 0 words load with last set, so only
  // serialised words ever advance.
  assign adv    = beat && !last_q;

  assign idx_nx  = msb_q ? idx_q - ONE
                         : idx_q + ONE;
  assign last_nx = msb_q ? (idx_nx == '0)
                         : (idx_nx == LAST_IDX);

  // Mode 0 shows the top slice, which is also
  // where an MSB-first stream starts.
  assign ld_idx = (mode_i && !msb_first_i)
                ? '0 : LAST_IDX;

  always_comb begin
    field_nx = data_i[FIELD_B_LSB +: FIELD_W];
    if (|data_i[CHK_W-1:0])
      field_nx = data_i[FIELD_A_LSB +: FIELD_W];
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = EMIT;
      EMIT: if (beat && last_q && !accept)
              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word datapath: load on accept, step on
  // non-last beats, otherwise hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q  <= '0;
      msb_q   <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      field_q <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          word_q  <= data_i;
          msb_q   <= msb_first_i;
          idx_q   <= ld_idx;
          last_q  <= !mode_i;
          field_q <= field_nx;
        end
        adv: begin
          idx_q  <= idx_nx;
          last_q <= last_nx;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    out_valid_o = valid;
    in_ready_o  = !valid
               || (out_ready_i && last_q);
    data_o  = word_q[int'(idx_q)*SLICE_W +: SLICE_W];
    idx_o   = idx_q;
    last_o  = last_q;
    field_o = field_q;
  end

endmodule

// File: tb/tb_bit_slicer_stream.sv
// tb_bit_slicer_stream: table-driven cycle vectors plus
// hand-written reset sequences for bit_slicer_stream.
module tb_bit_slicer_stream;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] data_i;
  logic        mode_i;
  logic        msb_first_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  data_o;
  logic [1:0]  idx_o;
  logic        last_o;
  logic [3:0]  field_o;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bit_slicer_stream dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .mode_i      (mode_i),
    .msb_first_i (msb_first_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .idx_o       (idx_o),
    .last_o      (last_o),
    .field_o     (field_o)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        m;
    logic        mf;
    logic        ordy;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  ei;
    logic        el;
    logic [3:0]  ef;
    logic        er;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic iv, input logic [31:0] d,
    input logic m, input logic mf,
    input logic ordy, input logic ev,
    input logic [7:0] ed, input logic [1:0] ei,
    input logic el, input logic [3:0] ef,
    input logic er);
    vec_t v;
    v.iv = iv; v.d = d; v.m = m; v.mf = mf;
    v.ordy = ordy; v.ev = ev; v.ed = ed;
    v.ei = ei; v.el = el; v.ef = ef; v.er = er;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag,
    input logic ev, input logic [7:0] ed,
    input logic [1:0] ei, input logic el,
    input logic [3:0] ef, input logic er);
    chk({tag, " valid"}, 32'(out_valid_o), 32'(ev));
    chk({tag, " data"},  32'(data_o),      32'(ed));
    chk({tag, " idx"},   32'(idx_o),       32'(ei));
    chk({tag, " last"},  32'(last_o),      32'(el));
    chk({tag, " field"}, 32'(field_o),     32'(ef));
    chk({tag, " inrdy"}, 32'(in_ready_o),  32'(er));
  endtask

  localparam logic [31:0] W_A = 32'hA1B2C3D4;
  localparam logic [31:0] W_B = 32'h00001E20;
  localparam logic [31:0] W_C = 32'h11223344;
  localparam logic [31:0] W_D = 32'h55667788;
  localparam logic [31:0] W_E = 32'h12345678;
  localparam logic [31:0] W_F = 32'hFFFFFFFF;

  initial begin
    // iv d m mf ordy | ev ed ei el ef er
    // LSB-first A1B2C3D4, mode/msb wiggle mid-word
    add(1, W_A, 1, 0, 1,  0, 8'h00, 0, 0, 4'h0, 1);
    add(0, 0,   1, 0, 1,  1, 8'hD4, 0, 0, 4'hA, 0);
    add(0, 0,   0, 1, 1,  1, 8'hC3, 1, 0, 4'hA, 0);
    add(0, 0,   0, 1, 1,  1, 8'hB2, 2, 0, 4'hA, 0);
    // last beat, accept MSB-first 00001E20
    add(1, W_B, 1, 1, 1,  1, 8'hA1, 3, 1, 4'hA, 1);
    add(0, 0,   1, 1, 1,  1, 8'h00, 3, 0, 4'hF, 0);
    add(0, 0,   1, 1, 1,  1, 8'h00, 2, 0, 4'hF, 0);
    add(0, 0,   1, 1, 1,  1, 8'h1E, 1, 0, 4'hF, 0);
    // last beat, accept mode 0 word
    add(1, W_A, 0, 1, 1,  1, 8'h20, 0, 1, 4'hF, 1);
    add(1, W_D, 0, 0, 1,  1, 8'hA1, 3, 1, 4'hA, 1);
    add(0, 0,   0, 0, 1,  1, 8'h55, 3, 1, 4'h4, 1);
    // idle hold, then back-to-back serialised
    add(1, W_C, 1, 0, 1,  0, 8'h55, 3, 1, 4'h4, 1);
    add(1, W_D, 1, 0, 1,  1, 8'h44, 0, 0, 4'h2, 0);
    add(1, W_D, 1, 0, 1,  1, 8'h33, 1, 0, 4'h2, 0);
    add(1, W_D, 1, 0, 1,  1, 8'h22, 2, 0, 4'h2, 0);
    add(1, W_D, 1, 0, 1,  1, 8'h11, 3, 1, 4'h2, 1);
    add(0, 0,   1, 0, 1,  1, 8'h88, 0, 0, 4'h4, 0);
    add(0, 0,   1, 0, 1,  1, 8'h77, 1, 0, 4'h4, 0);
    add(0, 0,   1, 0, 1,  1, 8'h66, 2, 0, 4'h4, 0);
    add(0, 0,   1, 0, 1,  1, 8'h55, 3, 1, 4'h4, 1);
    // backpressure at idx 2
    add(1, W_A, 1, 0, 1,  0, 8'h55, 3, 1, 4'h4, 1);
    add(0, 0,   1, 0, 1,  1, 8'hD4, 0, 0, 4'hA, 0);
    add(0, 0,   1, 0, 1,  1, 8'hC3, 1, 0, 4'hA, 0);
    add(0, 0,   1, 0, 0,  1, 8'hB2, 2, 0, 4'hA, 0);
    add(0, 0,   1, 0, 0,  1, 8'hB2, 2, 0, 4'hA, 0);
    add(0, 0,   1, 0, 0,  1, 8'hB2, 2, 0, 4'hA, 0);
    add(0, 0,   1, 0, 1,  1, 8'hB2, 2, 0, 4'hA, 0);
    add(0, 0,   1, 0, 1,  1, 8'hA1, 3, 1, 4'hA, 1);
    // stalled last beat blocks the next word
    add(1, W_E, 0, 0, 1,  0, 8'hA1, 3, 1, 4'hA, 1);
    add(1, W_F, 0, 0, 0,  1, 8'h12, 3, 1, 4'hC, 0);
    add(1, W_F, 0, 0, 1,  1, 8'h12, 3, 1, 4'hC, 1);
    add(0, 0,   0, 0, 1,  1, 8'hFF, 3, 1, 4'hF, 1);
    add(0, 0,   0, 0, 1,  0, 8'hFF, 3, 1, 4'hF, 1);

    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    data_i      = '0;
    mode_i      = 1'b0;
    msb_first_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 8'h00, 0, 0, 4'h0, 1);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      in_valid_i  = vq[i].iv;
      data_i      = vq[i].d;
      mode_i      = vq[i].m;
      msb_first_i = vq[i].mf;
      out_ready_i = vq[i].ordy;
      #1;
      chk_all($sformatf("vec%0d", i), vq[i].ev,
              vq[i].ed, vq[i].ei, vq[i].el,
              vq[i].ef, vq[i].er);
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a serialised word
    in_valid_i  = 1'b1;
    data_i      = W_A;
    mode_i      = 1'b1;
    msb_first_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk_all("mid idx1", 1, 8'hC3, 1, 0, 4'hA, 0);
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_all("async rst", 0, 8'h00, 0, 0, 4'h0, 1);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("post rst%0d", k),
              0, 8'h00, 0, 0, 4'h0, 1);
    end

    // Accept on the first edge after release
    rst_ni = 1'b0;
    #3;
    in_valid_i  = 1'b1;
    data_i      = W_B;
    mode_i      = 1'b1;
    msb_first_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    chk_all("first acc", 1, 8'h20, 0, 0, 4'hF, 0);
    @(posedge clk);
    #1;
    chk_all("first acc b1", 1, 8'h1E, 1, 0, 4'hF, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
